// File: rtl/ahb_sram_slave_if.sv
// AHB bus bundle between a master and the word SRAM slave.
// Master drives address/control/write data; slave returns ready/resp/rdata.
interface ahb_sram_slave_if;
    logic        s_HSEL;
    logic [31:0] s_HADDR;
    logic [1:0]  s_HTRANS;
    logic        s_HWRITE;
    logic [2:0]  s_HSIZE;
    logic [2:0]  s_HBURST;
    logic [31:0] s_HWDATA;
    logic        s_HREADY;
    logic        s_HREADYOUT;
    logic [1:0]  s_HRESP;
    logic [31:0] s_HRDATA;

    modport master (
        output s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE,
        output s_HBURST, s_HWDATA, s_HREADY,
        input  s_HREADYOUT, s_HRESP, s_HRDATA
    );

    modport slave (
        input  s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE,
        input  s_HBURST, s_HWDATA, s_HREADY,
        output s_HREADYOUT, s_HRESP, s_HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB word SRAM slave with programmable wait states and two-cycle ERROR.
// Read data is registered; same-edge write/read to one word is forwarded.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input logic s_HCLK,
    input logic s_HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state_q;
    state_t                state_n;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  write_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  legal;
    logic                  can_accept;
    logic                  take;
    logic                  commit;
    logic                  rd_write;
    logic                  load_rd;
    logic [ADDR_WIDTH-1:0] addr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [31:0]           rd_word;
    logic                  unused_in;

    assign addr_idx   = bus.s_HADDR[ADDR_WIDTH+1:2];
    assign accept     = bus.s_HSEL & bus.s_HREADY & bus.s_HTRANS[1];
    assign legal      = (bus.s_HSIZE == 3'b010) &&
                        (bus.s_HADDR[1:0] == 2'b00);
    assign can_accept = (state_q == ST_IDLE) ||
                        (state_q == ST_DATA) ||
                        (state_q == ST_ERR2);
    assign take       = accept & can_accept;
    assign commit     = (state_q == ST_DATA) & write_q;

    // A read entering the data phase from a wait uses the latched
    // transfer; with no waits it uses the address phase on the bus.
    assign rd_write = (state_q == ST_WAIT) ? write_q : bus.s_HWRITE;
    assign rd_idx   = (state_q == ST_WAIT) ? idx_q : addr_idx;
    assign load_rd  = (state_n == ST_DATA) & ~rd_write;
    assign rd_word  = (commit && idx_q == rd_idx) ? bus.s_HWDATA
                                                  : mem[rd_idx];

    assign unused_in = ^{bus.s_HBURST, bus.s_HTRANS[0],
                         bus.s_HADDR[31:ADDR_WIDTH+2]};

    // Ready and response come from state alone.
    assign bus.s_HREADYOUT = ~((state_q == ST_WAIT) ||
                               (state_q == ST_ERR1));
    assign bus.s_HRESP     = ((state_q == ST_ERR1) ||
                              (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign bus.s_HRDATA    = rdata_q;

    // Next-state decode; data and ERR2 phases accept pipelined transfers.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept && legal) begin
                    state_n = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                end else if (accept) begin
                    state_n = ST_ERR1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_n = ST_DATA;
                end
            end
            ST_ERR1: state_n = ST_ERR2;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, wait counter, transfer latches and registered read data.
    always_ff @(posedge s_HCLK) begin
        if (s_HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_n;
            rdata_q <= load_rd ? rd_word : 32'd0;
            if (take) begin
                idx_q   <= addr_idx;
                write_q <= bus.s_HWRITE;
            end
            if (take && legal) begin
                cnt_q <= 4'(WAIT_STATES);
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Write commit at the end of a write data phase; reset abandons it.
    always_ff @(posedge s_HCLK) begin
        if (!s_HRESET && commit) begin
            mem[idx_q] <= bus.s_HWDATA;
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait and a two-wait SRAM slave on one clock.
// Each single-slave bus ties HREADY back to the slave's HREADYOUT.
module tb_ahb_sram_slave;
    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_fail  = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    ahb_sram_slave_if bus_a ();
    ahb_sram_slave_if bus_b ();

    logic        a_sel, b_sel;
    logic [1:0]  a_tr, b_tr;
    logic        a_wr, b_wr;
    logic [31:0] a_ad, b_ad;
    logic [2:0]  a_sz, b_sz;
    logic [31:0] a_wd, b_wd;

    assign bus_a.s_HSEL   = a_sel;
    assign bus_a.s_HTRANS = a_tr;
    assign bus_a.s_HWRITE = a_wr;
    assign bus_a.s_HADDR  = a_ad;
    assign bus_a.s_HSIZE  = a_sz;
    assign bus_a.s_HBURST = 3'b011;
    assign bus_a.s_HWDATA = a_wd;
    assign bus_a.s_HREADY = bus_a.s_HREADYOUT;

    assign bus_b.s_HSEL   = b_sel;
    assign bus_b.s_HTRANS = b_tr;
    assign bus_b.s_HWRITE = b_wr;
    assign bus_b.s_HADDR  = b_ad;
    assign bus_b.s_HSIZE  = b_sz;
    assign bus_b.s_HBURST = 3'b011;
    assign bus_b.s_HWDATA = b_wd;
    assign bus_b.s_HREADY = bus_b.s_HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .s_HCLK   (clk),
        .s_HRESET (rst),
        .bus      (bus_a)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
        .s_HCLK   (clk),
        .s_HRESET (rst),
        .bus      (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_put(input logic sel, input logic [1:0] tr,
                         input logic wr, input logic [31:0] ad,
                         input logic [2:0] sz);
        a_sel = sel; a_tr = tr; a_wr = wr; a_ad = ad; a_sz = sz;
    endtask

    task automatic b_put(input logic sel, input logic [1:0] tr,
                         input logic wr, input logic [31:0] ad);
        b_sel = sel; b_tr = tr; b_wr = wr; b_ad = ad; b_sz = 3'b010;
    endtask

    task automatic a_rdy_resp(input string tag, input logic rdy,
                              input logic [1:0] resp);
        chk({tag, "_rdy"}, 32'(bus_a.s_HREADYOUT), 32'(rdy));
        chk({tag, "_resp"}, 32'(bus_a.s_HRESP), 32'(resp));
    endtask

    initial begin
        rst = 1'b1;
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        b_put(1'b0, T_IDLE, 1'b0, 32'h0);
        a_wd = 32'h0;
        b_wd = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;

        a_rdy_resp("rst_a", 1'b1, 2'b00);
        chk("rst_a_rdata", bus_a.s_HRDATA, 32'h0);
        chk("rst_b_rdy", 32'(bus_b.s_HREADYOUT), 32'd1);
        chk("rst_b_rdata", bus_b.s_HRDATA, 32'h0);

        // zero-wait write then read at 0x10
        a_put(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b010);
        cyc();
        a_rdy_resp("t1_wdata", 1'b1, 2'b00);
        a_wd = 32'hDEADBEEF;
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();
        a_rdy_resp("t1_idle", 1'b1, 2'b00);
        a_put(1'b1, T_NSEQ, 1'b0, 32'h10, 3'b010);
        cyc();
        a_rdy_resp("t1_rdata", 1'b1, 2'b00);
        chk("t1_rd", bus_a.s_HRDATA, 32'hDEADBEEF);
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();
        chk("t1_rd_clear", bus_a.s_HRDATA, 32'h0);

        // back-to-back write/read at 0x20 forwards write data
        a_put(1'b1, T_NSEQ, 1'b1, 32'h20, 3'b010);
        cyc();
        a_wd = 32'hA5A5A5A5;
        a_put(1'b1, T_NSEQ, 1'b0, 32'h20, 3'b010);
        cyc();
        chk("t3_fwd", bus_a.s_HRDATA, 32'hA5A5A5A5);
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();

        // halfword size write to 0x10: two-cycle ERROR, no write
        a_put(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b001);
        cyc();
        a_rdy_resp("t4s_err1", 1'b0, 2'b01);
        a_wd = 32'h12345678;
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();
        a_rdy_resp("t4s_err2", 1'b1, 2'b01);
        cyc();
        a_rdy_resp("t4s_after", 1'b1, 2'b00);

        // misaligned read at 0x22
        a_put(1'b1, T_NSEQ, 1'b0, 32'h22, 3'b010);
        cyc();
        a_rdy_resp("t4a_err1", 1'b0, 2'b01);
        chk("t4a_rdata", bus_a.s_HRDATA, 32'h0);
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();
        a_rdy_resp("t4a_err2", 1'b1, 2'b01);
        a_put(1'b1, T_NSEQ, 1'b0, 32'h10, 3'b010);
        cyc();
        chk("t4_mem_kept", bus_a.s_HRDATA, 32'hDEADBEEF);
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();

        // INCR4 write at 0x30 with a BUSY and a deselected cycle
        a_put(1'b1, T_NSEQ, 1'b1, 32'h30, 3'b010);
        cyc();
        a_wd = 32'h11;
        a_put(1'b1, T_BUSY, 1'b1, 32'h34, 3'b010);
        cyc();
        a_rdy_resp("t5_busy", 1'b1, 2'b00);
        a_put(1'b1, T_SEQ, 1'b1, 32'h34, 3'b010);
        cyc();
        a_wd = 32'h22;
        a_put(1'b0, T_SEQ, 1'b1, 32'h38, 3'b010);
        cyc();
        a_rdy_resp("t5_nosel", 1'b1, 2'b00);
        a_put(1'b1, T_SEQ, 1'b1, 32'h38, 3'b010);
        cyc();
        a_wd = 32'h33;
        a_put(1'b1, T_SEQ, 1'b1, 32'h3C, 3'b010);
        cyc();
        a_wd = 32'h44;
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();
        a_put(1'b1, T_NSEQ, 1'b0, 32'h30, 3'b010);
        cyc();
        chk("t5_rd0", bus_a.s_HRDATA, 32'h11);
        a_put(1'b1, T_SEQ, 1'b0, 32'h34, 3'b010);
        cyc();
        chk("t5_rd1", bus_a.s_HRDATA, 32'h22);
        a_put(1'b1, T_SEQ, 1'b0, 32'h38, 3'b010);
        cyc();
        chk("t5_rd2", bus_a.s_HRDATA, 32'h33);
        a_put(1'b1, T_SEQ, 1'b0, 32'h3C, 3'b010);
        cyc();
        chk("t5_rd3", bus_a.s_HRDATA, 32'h44);
        a_put(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
        cyc();

        // two-wait INCR4 write 1..4 at 0x100: 2 low + 1 high per beat
        b_put(1'b1, T_NSEQ, 1'b1, 32'h100);
        cyc();
        for (int i = 0; i < 4; i++) begin
            b_wd = 32'(i + 1);
            if (i < 3) b_put(1'b1, T_SEQ, 1'b1, 32'h100 + 32'(4 * (i + 1)));
            else b_put(1'b0, T_IDLE, 1'b0, 32'h0);
            chk($sformatf("t2w_b%0d_low0", i), 32'(bus_b.s_HREADYOUT), 32'd0);
            cyc();
            chk($sformatf("t2w_b%0d_low1", i), 32'(bus_b.s_HREADYOUT), 32'd0);
            cyc();
            chk($sformatf("t2w_b%0d_high", i), 32'(bus_b.s_HREADYOUT), 32'd1);
            cyc();
        end

        // INCR4 read back in order
        b_put(1'b1, T_NSEQ, 1'b0, 32'h100);
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) b_put(1'b1, T_SEQ, 1'b0, 32'h100 + 32'(4 * (i + 1)));
            else b_put(1'b0, T_IDLE, 1'b0, 32'h0);
            chk($sformatf("t2r_b%0d_low0", i), 32'(bus_b.s_HREADYOUT), 32'd0);
            cyc();
            chk($sformatf("t2r_b%0d_low1", i), 32'(bus_b.s_HREADYOUT), 32'd0);
            cyc();
            chk($sformatf("t2r_b%0d_high", i), 32'(bus_b.s_HREADYOUT), 32'd1);
            chk($sformatf("t2r_b%0d_data", i), bus_b.s_HRDATA, 32'(i + 1));
            chk($sformatf("t2r_b%0d_resp", i), 32'(bus_b.s_HRESP), 32'd0);
            cyc();
        end

        // preload 0x200, then reset in the middle of a write wait
        b_put(1'b1, T_NSEQ, 1'b1, 32'h200);
        cyc();
        b_wd = 32'h600D0001;
        b_put(1'b0, T_IDLE, 1'b0, 32'h0);
        cyc();
        cyc();
        cyc();
        b_put(1'b1, T_NSEQ, 1'b1, 32'h200);
        cyc();
        b_wd = 32'hBAD0BAD0;
        b_put(1'b0, T_IDLE, 1'b0, 32'h0);
        cyc();
        chk("t6_in_wait", 32'(bus_b.s_HREADYOUT), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_rdy", 32'(bus_b.s_HREADYOUT), 32'd1);
        chk("t6_rst_resp", 32'(bus_b.s_HRESP), 32'd0);
        chk("t6_rst_rdata", bus_b.s_HRDATA, 32'h0);
        cyc();
        chk("t6_stay_rdy", 32'(bus_b.s_HREADYOUT), 32'd1);
        b_put(1'b1, T_NSEQ, 1'b0, 32'h200);
        cyc();
        b_put(1'b0, T_IDLE, 1'b0, 32'h0);
        cyc();
        cyc();
        chk("t6_word_kept", bus_b.s_HRDATA, 32'h600D0001);
        cyc();

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
